// File: rtl/spi_rom_responder.sv
// ---------------------------------------------------------------------------
// spi_rom_responder
//
// SPI flash-ROM emulator answering the READ opcode (mode 0, MSB-first).
// The responder oversamples SCLK/CS/MOSI on the system clock. It decodes an
// 8-bit opcode followed by a 24-bit byte address. It then streams bytes from
// a synchronous byte memory onto MISO, with no gap between bytes, for as long
// as CS stays asserted. The address auto-increments and wraps at
// 2^ADDR_BITS. Unsupported opcodes are swallowed until CS drops, and they set
// a sticky flag.
//
// Ports
//   clk       in   system clock, at least 8x the SCLK frequency
//   reset_n   in   asynchronous active-low reset
//   spi_cs    in   chip select, CS_ACTIVE = selected
//   spi_sclk  in   SPI clock (idle low, sample on rise, shift on fall)
//   spi_mosi  in   command/address bits from the reader
//   spi_miso  out  data bits to the reader
//   rom_rd    out  one-cycle memory read strobe
//   rom_addr  out  memory byte address, valid while rom_rd = 1
//   rom_data  in   memory read data, valid one clk after rom_rd
//   busy      out  high whenever the responder is not idle
//   bad_cmd   out  sticky: an unsupported opcode was seen (reset clears it)
// ---------------------------------------------------------------------------
module spi_rom_responder #(
    parameter int         ADDR_BITS = 11,
    parameter logic       CS_ACTIVE = 1'b1,
    parameter logic [7:0] READ_CMD  = 8'h03
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 spi_cs,
    input  logic                 spi_sclk,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    output logic                 rom_rd,
    output logic [ADDR_BITS-1:0] rom_addr,
    input  logic [7:0]           rom_data,
    output logic                 busy,
    output logic                 bad_cmd
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        ADDR   = 3'd2,
        DATA   = 3'd3,
        IGNORE = 3'd4
    } state_t;

    // Two-flop synchronizers plus the previous synced SCLK for edge detection.
    logic [1:0] cs_sync_q;
    logic [1:0] sclk_sync_q;
    logic [1:0] mosi_sync_q;
    logic       sclk_prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_sync_q   <= {2{~CS_ACTIVE}};
            sclk_sync_q <= 2'b00;
            mosi_sync_q <= 2'b00;
            sclk_prev_q <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[0], spi_cs};
            sclk_sync_q <= {sclk_sync_q[0], spi_sclk};
            mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
            sclk_prev_q <= sclk_sync_q[1];
        end
    end

    logic cs_act;
    logic sclk_rise;
    logic sclk_fall;
    logic mosi_s;

    assign cs_act    = (cs_sync_q[1] == CS_ACTIVE);
    assign sclk_rise =  sclk_sync_q[1] & ~sclk_prev_q;
    assign sclk_fall = ~sclk_sync_q[1] &  sclk_prev_q;
    assign mosi_s    = mosi_sync_q[1];

    state_t               state_q;
    logic [7:0]           cmd_q;
    logic [2:0]           cmd_cnt_q;
    logic [23:0]          addr_q;
    logic [4:0]           addr_cnt_q;
    logic [7:0]           out_q;      // MISO shift register, MSB on the pin
    logic [7:0]           pre_q;      // prefetched next byte
    logic [2:0]           bit_cnt_q;  // bits of the current byte already shifted out
    logic                 rd_dly_q;   // rom_data is valid this cycle
    logic                 first_q;    // first byte of the burst not yet loaded
    logic                 skip_q;     // ignore the fall that ends the last address bit
    logic                 rom_rd_q;
    logic [ADDR_BITS-1:0] rom_addr_q;
    logic                 busy_q;
    logic                 bad_cmd_q;

    logic [7:0]           cmd_d;
    logic [23:0]          addr_d;
    logic [ADDR_BITS-1:0] addr_inc_d;

    always_comb begin
        cmd_d      = {cmd_q[6:0], mosi_s};
        addr_d     = {addr_q[22:0], mosi_s};
        addr_inc_d = rom_addr_q + {{(ADDR_BITS-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cmd_q      <= 8'h00;
            cmd_cnt_q  <= 3'd0;
            addr_q     <= 24'h000000;
            addr_cnt_q <= 5'd0;
            out_q      <= 8'h00;
            pre_q      <= 8'h00;
            bit_cnt_q  <= 3'd0;
            rd_dly_q   <= 1'b0;
            first_q    <= 1'b0;
            skip_q     <= 1'b0;
            rom_rd_q   <= 1'b0;
            rom_addr_q <= '0;
            busy_q     <= 1'b0;
            bad_cmd_q  <= 1'b0;
        end else begin
            rom_rd_q <= 1'b0;
            rd_dly_q <= rom_rd_q;
            if (!cs_act) begin
                // CS release wins over any SCLK edge in the same cycle; any
                // partial frame is discarded and any pending read is dropped.
                state_q    <= IDLE;
                busy_q     <= 1'b0;
                cmd_q      <= 8'h00;
                cmd_cnt_q  <= 3'd0;
                addr_q     <= 24'h000000;
                addr_cnt_q <= 5'd0;
                out_q      <= 8'h00;
                bit_cnt_q  <= 3'd0;
                rd_dly_q   <= 1'b0;
                first_q    <= 1'b0;
                skip_q     <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= CMD;
                        busy_q  <= 1'b1;
                        // A rise that coincides with CS arrival is opcode bit 7.
                        if (sclk_rise) begin
                            cmd_q     <= cmd_d;
                            cmd_cnt_q <= 3'd1;
                        end
                    end
                    CMD: begin
                        if (sclk_rise) begin
                            cmd_q     <= cmd_d;
                            cmd_cnt_q <= cmd_cnt_q + 3'd1;
                            if (cmd_cnt_q == 3'd7) begin
                                if (cmd_d == READ_CMD) begin
                                    state_q <= ADDR;
                                end else begin
                                    state_q   <= IGNORE;
                                    bad_cmd_q <= 1'b1;
                                end
                            end
                        end
                    end
                    ADDR: begin
                        if (sclk_rise) begin
                            addr_q <= addr_d;
                            if (addr_cnt_q == 5'd23) begin
                                // Upper address bits beyond the memory alias away.
                                addr_cnt_q <= 5'd0;
                                rom_addr_q <= addr_d[ADDR_BITS-1:0];
                                rom_rd_q   <= 1'b1;
                                state_q    <= DATA;
                                first_q    <= 1'b1;
                                skip_q     <= 1'b1;
                                bit_cnt_q  <= 3'd0;
                            end else begin
                                addr_cnt_q <= addr_cnt_q + 5'd1;
                            end
                        end
                    end
                    DATA: begin
                        if (rd_dly_q) begin
                            if (first_q) begin
                                // First byte goes straight to the pin and the
                                // prefetch of the next byte starts at once.
                                out_q      <= rom_data;
                                first_q    <= 1'b0;
                                rom_rd_q   <= 1'b1;
                                rom_addr_q <= addr_inc_d;
                            end else begin
                                pre_q <= rom_data;
                            end
                        end
                        if (sclk_fall) begin
                            if (skip_q) begin
                                // This fall closes address bit 0; the MSB already
                                // on MISO must survive until the next rise.
                                skip_q <= 1'b0;
                            end else if (bit_cnt_q == 3'd7) begin
                                out_q      <= pre_q;
                                bit_cnt_q  <= 3'd0;
                                rom_rd_q   <= 1'b1;
                                rom_addr_q <= addr_inc_d;
                            end else begin
                                out_q     <= {out_q[6:0], 1'b0};
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                            end
                        end
                    end
                    IGNORE: begin
                        state_q <= IGNORE;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // out_q is only non-zero in DATA, so MISO idles low everywhere else.
    assign spi_miso = out_q[7];
    assign rom_rd   = rom_rd_q;
    assign rom_addr = rom_addr_q;
    assign busy     = busy_q;
    assign bad_cmd  = bad_cmd_q;

endmodule

// File: tb/tb_spi_rom_responder.sv
// ---------------------------------------------------------------------------
// tb_spi_rom_responder
//
// Directed bench for spi_rom_responder. The bench plays the SPI reader in
// mode 0, with SCLK at clk/16, and models a synchronous 2 KiB byte memory.
// It checks reset behaviour, normal reads, bad opcodes, address wrap and
// aliasing, aborted frames, and a 16-byte burst.
// ---------------------------------------------------------------------------
module tb_spi_rom_responder;

    localparam int ADDR_BITS = 11;
    localparam int H         = 8;   // clk cycles per SCLK half period

    logic                 clk;
    logic                 reset_n;
    logic                 spi_cs;
    logic                 spi_sclk;
    logic                 spi_mosi;
    logic                 spi_miso;
    logic                 rom_rd;
    logic [ADDR_BITS-1:0] rom_addr;
    logic [7:0]           rom_data;
    logic                 busy;
    logic                 bad_cmd;

    spi_rom_responder #(
        .ADDR_BITS (ADDR_BITS),
        .CS_ACTIVE (1'b1),
        .READ_CMD  (8'h03)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .spi_cs   (spi_cs),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .rom_rd   (rom_rd),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .busy     (busy),
        .bad_cmd  (bad_cmd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: data appears one clk after the read strobe.
    logic [7:0] mem [0:2047];
    always @(posedge clk) begin
        if (rom_rd) rom_data <= mem[rom_addr];
    end

    // Read-strobe log.
    logic [ADDR_BITS-1:0] rd_log [0:63];
    int                   rd_cnt;
    always @(negedge clk) begin
        if (rom_rd) begin
            if (rd_cnt < 64) rd_log[rd_cnt] = rom_addr;
            rd_cnt = rd_cnt + 1;
        end
    end

    int         n_checks;
    int         n_errors;
    logic [7:0] rx_bytes [0:15];
    logic       miso_or;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One SCLK period: set MOSI while low, sample MISO just before the rise.
    task automatic spi_bit(input logic m, output logic s);
        spi_mosi = m;
        repeat (H) @(negedge clk);
        s        = spi_miso;
        miso_or  = miso_or | spi_miso;
        spi_sclk = 1'b1;
        repeat (H) @(negedge clk);
        spi_sclk = 1'b0;
    endtask

    task automatic spi_begin();
        miso_or  = 1'b0;
        rd_cnt   = 0;
        spi_sclk = 1'b0;
        spi_cs   = 1'b1;
        repeat (H) @(negedge clk);
    endtask

    task automatic spi_end();
        repeat (H) @(negedge clk);
        spi_cs   = 1'b0;
        spi_mosi = 1'b0;
        repeat (H) @(negedge clk);
    endtask

    task automatic spi_header(input logic [7:0] cmd, input logic [23:0] addr, input int nabits);
        logic s;
        for (int i = 7; i >= 0; i--) spi_bit(cmd[i], s);
        for (int i = 0; i < nabits; i++) spi_bit(addr[23-i], s);
    endtask

    task automatic spi_read(input logic [7:0] cmd, input logic [23:0] addr, input int nbytes);
        logic s;
        logic [7:0] b;
        spi_begin();
        spi_header(cmd, addr, 24);
        for (int k = 0; k < nbytes; k++) begin
            b = 8'h00;
            for (int i = 0; i < 8; i++) begin
                spi_bit(1'b0, s);
                b = {b[6:0], s};
            end
            rx_bytes[k] = b;
        end
        spi_end();
    endtask

    initial begin
        logic s;
        n_checks = 0;
        n_errors = 0;
        rd_cnt   = 0;
        miso_or  = 1'b0;
        rom_data = 8'h00;
        for (int i = 0; i < 2048; i++) mem[i] = 8'((i * 7 + 3) & 8'hFF);
        mem[11'h010] = 8'hA5;
        mem[11'h011] = 8'h3C;
        mem[11'h020] = 8'hFF;
        mem[11'h7FF] = 8'h69;
        mem[11'h000] = 8'hC3;

        // Reset state
        reset_n  = 1'b0;
        spi_cs   = 1'b0;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_miso",    32'(spi_miso), 32'h0);
        check("rst_busy",    32'(busy),     32'h0);
        check("rst_rom_rd",  32'(rom_rd),   32'h0);
        check("rst_rom_addr",32'(rom_addr), 32'h0);
        check("rst_bad_cmd", 32'(bad_cmd),  32'h0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // Reset asserted mid-burst clears outputs immediately
        spi_begin();
        spi_header(8'h03, 24'h000020, 24);
        for (int i = 0; i < 4; i++) spi_bit(1'b0, s);
        repeat (2) @(negedge clk);
        check("mid_miso_hi", 32'(spi_miso), 32'h1);
        check("mid_busy_hi", 32'(busy),     32'h1);
        reset_n = 1'b0;
        #1;
        check("arst_miso",   32'(spi_miso), 32'h0);
        check("arst_busy",   32'(busy),     32'h0);
        check("arst_rom_rd", 32'(rom_rd),   32'h0);
        spi_cs = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // Two-byte read from 0x000010
        spi_read(8'h03, 24'h000010, 2);
        check("rd2_byte0", 32'(rx_bytes[0]), 32'hA5);
        check("rd2_byte1", 32'(rx_bytes[1]), 32'h3C);
        check("rd2_rdcnt", 32'(rd_cnt),      32'd4);
        check("rd2_addr0", 32'(rd_log[0]),   32'h010);
        check("rd2_addr1", 32'(rd_log[1]),   32'h011);
        check("rd2_addr3", 32'(rd_log[3]),   32'h013);
        check("rd2_busy_after", 32'(busy),     32'h0);
        check("rd2_miso_after", 32'(spi_miso), 32'h0);

        // Unsupported opcode, then a good frame
        spi_read(8'h0B, 24'h000010, 1);
        check("bad_miso_any", 32'(miso_or), 32'h0);
        check("bad_flag",     32'(bad_cmd), 32'h1);
        check("bad_rdcnt",    32'(rd_cnt),  32'd0);
        spi_read(8'h03, 24'h000010, 1);
        check("bad_next_byte", 32'(rx_bytes[0]), 32'hA5);
        check("bad_sticky",    32'(bad_cmd),     32'h1);

        // Address wrap at the top of memory
        spi_read(8'h03, 24'h0007FF, 2);
        check("wrap_addr0", 32'(rd_log[0]),   32'h7FF);
        check("wrap_addr1", 32'(rd_log[1]),   32'h000);
        check("wrap_byte0", 32'(rx_bytes[0]), 32'h69);
        check("wrap_byte1", 32'(rx_bytes[1]), 32'hC3);

        // Upper address bits alias
        spi_read(8'h03, 24'hFFF800, 1);
        check("alias_addr", 32'(rd_log[0]),   32'h000);
        check("alias_byte", 32'(rx_bytes[0]), 32'hC3);

        // CS dropped after 20 address bits
        spi_begin();
        spi_header(8'h03, 24'h000010, 20);
        spi_end();
        check("abort_rdcnt", 32'(rd_cnt),   32'd0);
        check("abort_busy",  32'(busy),     32'h0);
        check("abort_miso",  32'(spi_miso), 32'h0);
        spi_read(8'h03, 24'h000011, 1);
        check("abort_next_byte", 32'(rx_bytes[0]), 32'h3C);

        // 128-bit burst, gapless across byte boundaries
        spi_read(8'h03, 24'h000100, 16);
        for (int k = 0; k < 16; k++)
            check($sformatf("burst_b%0d", k), 32'(rx_bytes[k]), 32'(mem[11'h100 + k]));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
